// File: rtl/key_encoder_pkg.sv
// Shared types and helpers for the key encoder: line count, code width, priority encode.
// Pure package, no logic; no latency or backpressure of its own.
package key_encoder_pkg;

    localparam int LINES  = 8;
    localparam int CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    // Highest set index wins; an all-zero vector encodes to 0.
    function automatic code_t prio_enc(input logic [LINES-1:0] vec);
        code_t idx;
        idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (vec[i]) begin
                idx = code_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic more_than_one(input logic [LINES-1:0] vec);
        return (vec & (vec - LINES'(1))) != '0;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// DEPTH x code_t synchronous FIFO with a registered count that separates full from empty.
// Latency: a push is visible at head after its edge; head is 0 while empty.
// Backpressure: push while full is refused unless a pop happens on the same edge.
module code_fifo
    import key_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  code_t push_dat,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output code_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("code_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    code_t            mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    // A pop on an empty FIFO is meaningless; a push into a full one needs a pop to make room.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_encoder.sv
// 8-to-3 sequential key encoder: sync, optional debounce (KEY_ENCODER_DEBOUNCE_EN), rise detect, FIFO.
// Latency: DB_CYCLES+3 edges from a line rising to valid with debounce, 4 without.
// Backpressure: valid/ready drain; events arriving while full and not draining are dropped and flag ovf.
module key_encoder
    import key_encoder_pkg::*;
#(
    parameter int DB_CYCLES = 1000,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LINES-1:0] y,
    input  logic             ready,
    output code_t            code,
    output logic             valid,
    output logic             multi,
    output logic             ovf
);

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("key_encoder: DB_CYCLES must be at least 1");
    end

    logic [LINES-1:0] s1;
    logic [LINES-1:0] s2;
    logic [LINES-1:0] stable;
    logic [LINES-1:0] prev;
    logic [LINES-1:0] rise;
    logic             ev_vld;
    code_t            ev_code;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= y;
            s2 <= s1;
        end
    end

`ifdef KEY_ENCODER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [LINES];

    // A new level is accepted on the DB_CYCLES-th consecutive edge that still disagrees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < LINES; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
        end else begin
            stable <= s2;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= stable;
        end
    end

    assign rise    = stable & ~prev;
    assign ev_vld  = |rise;
    assign ev_code = prio_enc(rise);
    assign multi   = more_than_one(rise);
    // Full implies valid, so a drop is simply an event meeting a full FIFO with ready low.
    assign drop    = ev_vld & fifo_full & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    code_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ev_vld),
        .push_dat (ev_code),
        .pop      (ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (code)
    );

    assign valid = ~fifo_empty;

endmodule

// File: tb/tb_key_encoder.sv
// Directed bench for key_encoder with a code scoreboard; latency follows KEY_ENCODER_DEBOUNCE_EN.
module tb_key_encoder;
    import key_encoder_pkg::*;

    localparam int DB    = 4;
    localparam int DEPTH = 4;
`ifdef KEY_ENCODER_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 4;
`endif
    localparam int HOLD = LAT + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] y;
    logic       ready;
    code_t      code;
    logic       valid;
    logic       multi;
    logic       ovf;

    int    checks = 0;
    int    errors = 0;
    code_t exp_q[$];

    key_encoder #(
        .DB_CYCLES (DB),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .ready (ready),
        .code  (code),
        .valid (valid),
        .multi (multi),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkc(input string tag, input code_t obs, input code_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare the DUT head against the oldest expected code and retire it.
    task automatic expect_head(input string tag);
        code_t e;
        checkb({tag, "_valid"}, valid, 1'b1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=%0d expected=none (scoreboard empty)", tag, code);
        end else begin
            e = exp_q.pop_front();
            checkc({tag, "_code"}, code, e);
        end
    endtask

    initial begin
        logic seen;

        // Reset with every line held high.
        rst_n = 1'b0;
        y     = 8'hFF;
        ready = 1'b0;
        tick(3);
        checkc("rst_code", code, 3'd0);
        checkb("rst_valid", valid, 1'b0);
        checkb("rst_multi", multi, 1'b0);
        checkb("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        exp_q.push_back(3'd7);
        tick(LAT - 1);
        checkb("rst_multi_pulse", multi, 1'b1);
        checkb("rst_early_valid", valid, 1'b0);
        tick(1);
        checkb("rst_multi_off", multi, 1'b0);
        ready = 1'b1;
        expect_head("rst_head");
        tick(1);
        checkb("rst_single_entry", valid, 1'b0);
        y = 8'h00;
        tick(HOLD);
        checkb("rst_release_quiet", valid, 0);

        // Single press: valid for exactly one cycle with ready held high.
        exp_q.push_back(3'd5);
        y = 8'h20;
        tick(LAT - 1);
        checkb("press_early", valid, 1'b0);
        tick(1);
        expect_head("press_head");
        tick(1);
        checkb("press_one_cycle", valid, 1'b0);
        y = 8'h00;
        tick(HOLD);
        checkb("press_release_quiet", valid, 1'b0);

        // Simultaneous press of lines 0 and 6, held without draining.
        ready = 1'b0;
        exp_q.push_back(3'd6);
        y = 8'h41;
        tick(LAT - 1);
        checkb("simul_multi", multi, 1'b1);
        tick(1);
        checkb("simul_multi_off", multi, 1'b0);
        tick(HOLD);
        expect_head("simul_head_held");
        ready = 1'b1;
        tick(1);
        checkb("simul_count_one", valid, 1'b0);
        y = 8'h00;
        tick(HOLD);

        // Three-cycle glitch on line 3.
        y = 8'h08;
        tick(3);
        y = 8'h00;
`ifdef KEY_ENCODER_DEBOUNCE_EN
        tick(HOLD);
        checkb("glitch_rejected", valid, 1'b0);
`else
        exp_q.push_back(3'd3);
        tick(LAT - 3);
        expect_head("glitch_head");
        tick(1);
        checkb("glitch_single", valid, 1'b0);
        tick(HOLD);
`endif
        checkb("glitch_no_ovf", ovf, 1'b0);

        // Overflow: five presses into a four-entry FIFO.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            y = 8'(1 << i);
            if (i < DEPTH) exp_q.push_back(code_t'(i));
            tick(HOLD);
            y = 8'h00;
            tick(HOLD);
            if (i == DEPTH - 1) checkb("ovf_before_fifth", ovf, 1'b0);
        end
        checkb("ovf_set", ovf, 1'b1);
        ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            expect_head("ovf_drain");
            tick(1);
        end
        checkb("ovf_drained", valid, 1'b0);
        checkb("ovf_sticky", ovf, 1'b1);

        // Reset mid-operation with three entries queued.
        ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            y = 8'(1 << i);
            exp_q.push_back(code_t'(i));
            tick(HOLD);
            y = 8'h00;
            tick(HOLD);
        end
        checkb("mid_queued", valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkb("mid_async_valid", valid, 1'b0);
        checkb("mid_async_ovf", ovf, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 2 * HOLD; c++) begin
            if (valid) seen = 1'b1;
            tick(1);
        end
        checkb("mid_no_stale", seen, 1'b0);

        // FIFO still works after the flush.
        exp_q.push_back(3'd4);
        y = 8'h10;
        tick(LAT);
        expect_head("post_rst_head");
        tick(1);
        checkb("post_rst_single", valid, 1'b0);
        y = 8'h00;
        tick(HOLD);
        checkb("post_rst_ovf", ovf, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
